// File: rtl/systolic_out_writer_pkg.sv
// Shared constants and FSM encoding for the systolic array drain writer.
// Accumulator lane width, requantization saturation bounds and drain states.
package systolic_out_writer_pkg;

    localparam int OUTCOME_WIDTH = 21;
    localparam int QMAX = 127;
    localparam int QMIN = -128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_LAST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/systolic_out_writer_quant.sv
// Combinational requantizer for one accumulator lane:
// round-half-up right shift followed by saturation to the signed output range.
module out_quantizer
    import systolic_out_writer_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [OUTCOME_WIDTH-1:0] outcome,
    input  logic [3:0]               shift_amt,
    output logic [DATA_WIDTH-1:0]    quant
);

    // One guard bit keeps the rounding add from overflowing.
    localparam int EW = OUTCOME_WIDTH + 1;

    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] bias;
    logic signed [EW-1:0] sum;
    logic signed [EW-1:0] shifted;

    always_comb begin
        ext  = {outcome[OUTCOME_WIDTH-1], outcome};
        bias = '0;
        if (shift_amt != 4'd0) begin
            bias = EW'(1) << (shift_amt - 4'd1);
        end
        sum     = ext + bias;
        shifted = sum >>> shift_amt;
        if (shifted > $signed(EW'(QMAX))) begin
            quant = DATA_WIDTH'(QMAX);
        end else if (shifted < $signed(EW'(QMIN))) begin
            quant = DATA_WIDTH'(QMIN);
        end else begin
            quant = shifted[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/systolic_out_writer.sv
// Drain-side writer: steps matrix_index over all output vectors, requantizes
// each lane and writes the packed vector to the output SRAM pair one cycle later.
module systolic_out_writer
    import systolic_out_writer_pkg::*;
#(
    parameter int ARRAY_SIZE      = 8,
    parameter int SRAM_DATA_WIDTH = 32,
    parameter int DATA_WIDTH      = 8,
    parameter int ADDR_WIDTH      = 10
) (
    input  logic                                clk,
    input  logic                                srstn,
    input  logic                                start,
    input  logic [3:0]                          shift_amt,
    input  logic [ADDR_WIDTH-1:0]               base_addr,
    input  logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0] mul_outcome,
    output logic [5:0]                          matrix_index,
    output logic                                sram_wen,
    output logic [ADDR_WIDTH-1:0]               sram_waddr,
    output logic [SRAM_DATA_WIDTH-1:0]          sram_wdata0,
    output logic [SRAM_DATA_WIDTH-1:0]          sram_wdata1,
    output logic                                busy,
    output logic                                done
);

    localparam int VW = 2 * SRAM_DATA_WIDTH;

    generate
        if (ARRAY_SIZE * DATA_WIDTH != VW) begin : g_bad_geometry
            $error("ARRAY_SIZE*DATA_WIDTH must equal 2*SRAM_DATA_WIDTH");
        end
    endgenerate

    state_t                  state_reg, state_next;
    logic [5:0]              idx_reg, idx_next;
    logic [3:0]              shift_reg, shift_next;
    logic [ADDR_WIDTH-1:0]   base_reg, base_next;
    logic                    wen_reg, wen_next;
    logic [ADDR_WIDTH-1:0]   waddr_reg, waddr_next;
    logic [VW-1:0]           wdata_reg, wdata_next;
    logic [VW-1:0]           quant_vec;

    // Lane 0 lands in the MSB byte of word 0; lane ARRAY_SIZE/2 in the MSB byte of word 1.
    genvar gi;
    generate
        for (gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
            out_quantizer #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_quant (
                .outcome   (mul_outcome[gi*OUTCOME_WIDTH +: OUTCOME_WIDTH]),
                .shift_amt (shift_reg),
                .quant     (quant_vec[VW-1-gi*DATA_WIDTH -: DATA_WIDTH])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            shift_reg <= '0;
            base_reg  <= '0;
            wen_reg   <= 1'b1;
            waddr_reg <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            shift_reg <= shift_next;
            base_reg  <= base_next;
            wen_reg   <= wen_next;
            waddr_reg <= waddr_next;
            wdata_reg <= wdata_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        shift_next = shift_reg;
        base_next  = base_reg;
        wen_next   = 1'b1;
        waddr_next = waddr_reg;
        wdata_next = wdata_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    shift_next = shift_amt;
                    base_next  = base_addr;
                    idx_next   = '0;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wen_next   = 1'b0;
                waddr_next = base_reg + ADDR_WIDTH'(idx_reg);
                wdata_next = quant_vec;
                idx_next   = idx_reg + 6'd1;
                if (idx_reg == 6'(ARRAY_SIZE - 1)) begin
                    state_next = ST_LAST;
                end
            end
            ST_LAST: begin
                // Final vector is on the SRAM port this cycle.
                idx_next   = '0;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                idx_next   = '0;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign matrix_index = idx_reg;
    assign sram_wen     = wen_reg;
    assign sram_waddr   = waddr_reg;
    assign sram_wdata0  = wdata_reg[VW-1 -: SRAM_DATA_WIDTH];
    assign sram_wdata1  = wdata_reg[SRAM_DATA_WIDTH-1:0];
    assign busy         = (state_reg == ST_ISSUE) || (state_reg == ST_LAST);
    assign done         = (state_reg == ST_DONE);

endmodule

// File: tb/tb_systolic_out_writer.sv
// Self-checking bench for systolic_out_writer: randomized drains compared
// against an arithmetic requantize/pack model and a cycle-indexed write schedule.
module tb_systolic_out_writer;

    localparam int AS = 8;
    localparam int OW = 21;

    logic             clk = 1'b0;
    logic             srstn;
    logic             start;
    logic [3:0]       shift_amt;
    logic [9:0]       base_addr;
    logic [AS*OW-1:0] mul_outcome;
    logic [5:0]       matrix_index;
    logic             sram_wen;
    logic [9:0]       sram_waddr;
    logic [31:0]      sram_wdata0;
    logic [31:0]      sram_wdata1;
    logic             busy;
    logic             done;

    systolic_out_writer dut (
        .clk          (clk),
        .srstn        (srstn),
        .start        (start),
        .shift_amt    (shift_amt),
        .base_addr    (base_addr),
        .mul_outcome  (mul_outcome),
        .matrix_index (matrix_index),
        .sram_wen     (sram_wen),
        .sram_waddr   (sram_waddr),
        .sram_wdata0  (sram_wdata0),
        .sram_wdata1  (sram_wdata1),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    logic [OW-1:0] vec [AS][AS];
    logic [31:0]   cap_d0 [AS];
    logic [31:0]   cap_d1 [AS];

    // Behaves like the array: the selected vector appears combinationally.
    always_comb begin
        mul_outcome = '0;
        if (matrix_index < AS) begin
            for (int i = 0; i < AS; i++) begin
                mul_outcome[i*OW +: OW] = vec[matrix_index[2:0]][i];
            end
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [7:0] quant(input logic [OW-1:0] v, input int s);
        int x;
        int r;
        x = $signed(v);
        if (s == 0) r = x;
        else        r = (x + (1 << (s - 1))) >>> s;
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        return r[7:0];
    endfunction

    function automatic logic [63:0] model_word(input int k, input int s);
        logic [63:0] w;
        for (int i = 0; i < AS; i++) w[63-8*i -: 8] = quant(vec[k][i], s);
        return w;
    endfunction

    task automatic fill_random();
        for (int k = 0; k < AS; k++) begin
            for (int i = 0; i < AS; i++) begin
                if ($urandom_range(0, 1) == 1) vec[k][i] = OW'($urandom);
                else vec[k][i] = OW'($urandom_range(0, 4000)) - OW'(2000);
            end
        end
    endtask

    // Called just after a rising edge; start is sampled at the next edge.
    // Cycle c counts sample points after that edge; writes expected at c=2..AS+1.
    task automatic drain(input string tag, input logic [9:0] base, input logic [3:0] sh,
                         input int restart_c, input int abort_c);
        logic [63:0] w;
        logic [9:0]  ea;
        bit          exp_wr;
        int          k;
        start     = 1'b1;
        shift_amt = sh;
        base_addr = base;
        for (int c = 1; c <= AS + 5; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                start     = 1'b0;
                shift_amt = 4'($urandom);
                base_addr = 10'($urandom);
            end
            if (abort_c > 0 && c > abort_c) begin
                check({tag, "_rst_wen"}, 32'(sram_wen), 32'd1);
                check({tag, "_rst_busy"}, 32'(busy), 32'd0);
                check({tag, "_rst_done"}, 32'(done), 32'd0);
                check({tag, "_rst_idx"}, 32'(matrix_index), 32'd0);
            end else begin
                exp_wr = (c >= 2) && (c <= AS + 1);
                k      = c - 2;
                check({tag, "_wen"}, 32'(sram_wen), exp_wr ? 32'd0 : 32'd1);
                check({tag, "_busy"}, 32'(busy), (c <= AS + 1) ? 32'd1 : 32'd0);
                check({tag, "_done"}, 32'(done), (c == AS + 2) ? 32'd1 : 32'd0);
                if (c <= AS) check({tag, "_idx"}, 32'(matrix_index), 32'(c - 1));
                if (exp_wr) begin
                    w  = model_word(k, int'(sh));
                    ea = base + 10'(k);
                    cap_d0[k] = sram_wdata0;
                    cap_d1[k] = sram_wdata1;
                    $display("%s write k=%0d addr=0x%03h d0=0x%08h d1=0x%08h",
                             tag, k, sram_waddr, sram_wdata0, sram_wdata1);
                    check({tag, "_addr"}, 32'(sram_waddr), 32'(ea));
                    check({tag, "_d0"}, sram_wdata0, w[63:32]);
                    check({tag, "_d1"}, sram_wdata1, w[31:0]);
                end
            end
            if (c == restart_c) start = 1'b1;
            else if (c == restart_c + 1) start = 1'b0;
            if (c == abort_c) srstn = 1'b0;
            if (abort_c > 0 && c == abort_c + 1) srstn = 1'b1;
        end
    endtask

    initial begin
        srstn     = 1'b0;
        start     = 1'b0;
        shift_amt = '0;
        base_addr = '0;
        for (int k = 0; k < AS; k++)
            for (int i = 0; i < AS; i++) vec[k][i] = '0;

        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_wen", 32'(sram_wen), 32'd1);
        check("reset_waddr", 32'(sram_waddr), 32'd0);
        check("reset_d0", sram_wdata0, 32'd0);
        check("reset_d1", sram_wdata1, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_idx", 32'(matrix_index), 32'd0);
        srstn = 1'b1;

        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            check("idle_wen", 32'(sram_wen), 32'd1);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(done), 32'd0);
            check("idle_idx", 32'(matrix_index), 32'd0);
        end

        for (int k = 0; k < AS; k++)
            for (int i = 0; i < AS; i++) vec[k][i] = OW'(16 * k + i);
        drain("basic", 10'h040, 4'd0, 0, 0);
        check("basic_k1_d0", cap_d0[1], 32'h10111213);
        check("basic_k1_d1", cap_d1[1], 32'h14151617);

        fill_random();
        vec[1][0] = 21'h000018;
        vec[1][1] = 21'h1FFFE8;
        vec[1][2] = 21'h004000;
        vec[1][3] = 21'h1F0000;
        drain("round", 10'($urandom), 4'd4, 0, 0);
        check("round_k1_d0", cap_d0[1], 32'h02FF7F80);

        fill_random();
        drain("busy_start", 10'($urandom), 4'($urandom), 3, 0);

        fill_random();
        drain("done_start", 10'($urandom), 4'($urandom), AS + 2, 0);

        fill_random();
        drain("abort", 10'($urandom), 4'($urandom), 0, 4);
        fill_random();
        drain("after_abort", 10'($urandom), 4'($urandom), 0, 0);

        fill_random();
        drain("wrap", 10'h3FC, 4'($urandom_range(0, 8)), 0, 0);

        for (int r = 0; r < 4; r++) begin
            fill_random();
            drain("rand", 10'($urandom), 4'($urandom), 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
